// File: rtl/tone_sequencer.sv
// Melody playback controller: walks a synchronous melody ROM entry by entry,
// pacing notes and articulation gaps from the tempo strobe.
`timescale 1ns/1ps

module tone_sequencer #(
    parameter int ADDR_BW   = 6,
    parameter int DUR_BW    = 4,
    parameter int GAP_TICKS = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                loop_i,
    input  logic                tick_i,
    output logic [ADDR_BW-1:0]  rom_addr_o,
    input  logic [DUR_BW+6:0]   rom_data_i,
    output logic [5:0]          note_index_o,
    output logic                gate_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int GAP_BW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    state_t              state_q;
    logic [ADDR_BW-1:0]  addr_q;
    logic [5:0]          note_q;
    logic                gate_q;
    logic                done_q;
    logic                last_q;
    logic [DUR_BW-1:0]   dur_q;
    logic [GAP_BW-1:0]   gap_q;

    logic [5:0]          rom_note;
    logic [DUR_BW-1:0]   rom_dur;
    logic                rom_last;

    assign rom_note = rom_data_i[5:0];
    assign rom_dur  = rom_data_i[6 +: DUR_BW];
    assign rom_last = rom_data_i[6 + DUR_BW];

    // Outcome of finishing the current entry, shared by PLAY and GAP.
    state_t              adv_state_d;
    logic [ADDR_BW-1:0]  adv_addr_d;
    logic                adv_done_d;
    logic                adv_gate_d;

    always_comb begin
        adv_state_d = S_FETCH;
        adv_addr_d  = addr_q + ADDR_BW'(1);
        adv_done_d  = 1'b0;
        adv_gate_d  = gate_q;
        unique case (1'b1)
            !last_q: begin
                adv_addr_d = addr_q + ADDR_BW'(1);
            end
            last_q && loop_i: begin
                adv_addr_d = '0;
            end
            last_q && !loop_i: begin
                adv_addr_d  = '0;
                adv_state_d = S_IDLE;
                adv_done_d  = 1'b1;
                adv_gate_d  = 1'b0;
            end
            default: begin
                adv_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
            dur_q   <= '0;
            gap_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop_i) begin
                state_q <= S_IDLE;
                addr_q  <= '0;
                gate_q  <= 1'b0;
                dur_q   <= '0;
                gap_q   <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        addr_q <= '0;
                        gate_q <= 1'b0;
                        if (start_i) begin
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state_q <= S_LOAD;
                    end
                    S_LOAD: begin
                        note_q  <= rom_note;
                        dur_q   <= rom_dur;
                        last_q  <= rom_last;
                        gate_q  <= (rom_note != 6'd0);
                        state_q <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (tick_i) begin
                            if (dur_q != '0) begin
                                dur_q <= dur_q - DUR_BW'(1);
                            end else if (GAP_TICKS > 0) begin
                                gap_q   <= GAP_BW'(GAP_TICKS - 1);
                                gate_q  <= 1'b0;
                                state_q <= S_GAP;
                            end else begin
                                state_q <= adv_state_d;
                                addr_q  <= adv_addr_d;
                                done_q  <= adv_done_d;
                                gate_q  <= adv_gate_d;
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick_i) begin
                            if (gap_q != '0) begin
                                gap_q <= gap_q - GAP_BW'(1);
                            end else begin
                                state_q <= adv_state_d;
                                addr_q  <= adv_addr_d;
                                done_q  <= adv_done_d;
                                gate_q  <= adv_gate_d;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr_o   = addr_q;
    assign note_index_o = note_q;
    assign gate_o       = gate_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: vector tables through a scoreboard queue,
// plus async reset and 64-entry address wrap sequences.
`timescale 1ns/1ps

module tb_tone_sequencer;

    localparam int AW = 6;
    localparam int DW = 4;
    localparam int RW = 7 + DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, stop, loop_l, tick;
    logic [AW-1:0] addr;
    logic [RW-1:0] rdata;
    logic [5:0]    note;
    logic          gate, busy, done;

    logic          start2, stop2, loop2, tick2;
    logic [AW-1:0] addr2;
    logic [RW-1:0] rdata2;
    logic [5:0]    note2;
    logic          gate2, busy2, done2;

    logic [RW-1:0] mem1 [64];
    logic [RW-1:0] mem2 [64];

    always @(posedge clk) rdata  <= mem1[addr];
    always @(posedge clk) rdata2 <= mem2[addr2];

    tone_sequencer #(.ADDR_BW(AW), .DUR_BW(DW), .GAP_TICKS(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .start_i(start), .stop_i(stop), .loop_i(loop_l), .tick_i(tick),
        .rom_addr_o(addr), .rom_data_i(rdata),
        .note_index_o(note), .gate_o(gate), .busy_o(busy), .done_o(done)
    );

    tone_sequencer #(.ADDR_BW(AW), .DUR_BW(DW), .GAP_TICKS(0)) dut_legato (
        .clk_i(clk), .rst_n_i(rst_n),
        .start_i(start2), .stop_i(stop2), .loop_i(loop2), .tick_i(tick2),
        .rom_addr_o(addr2), .rom_data_i(rdata2),
        .note_index_o(note2), .gate_o(gate2), .busy_o(busy2), .done_o(done2)
    );

    typedef struct packed {
        logic       st, sp, lp, tk;
        logic [5:0] note;
        logic       gate, busy, done;
        logic [5:0] addr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    vec_t e;
    int   n_run  = 0;
    int   n_fail = 0;
    int   vec_no = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input bit st, sp, lp, tk, input int nt,
                                input bit g, b, d, input int a);
        vec_t v;
        v = '{st, sp, lp, tk, 6'(nt), g, b, d, 6'(a)};
        tbl.push_back(v);
    endfunction

    // Scoreboard: expected outputs pop one edge after their inputs were driven.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vec_no++;
            n_run++;
            if ({note, gate, busy, done, addr} !==
                {e.note, e.gate, e.busy, e.done, e.addr}) begin
                n_fail++;
                $display("FAIL vec%0d: got note=%0d gate=%b busy=%b done=%b addr=%0d expected note=%0d gate=%b busy=%b done=%b addr=%0d",
                         vec_no, note, gate, busy, done, addr,
                         e.note, e.gate, e.busy, e.done, e.addr);
            end
        end
    end

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start  = tbl[i].st;
            stop   = tbl[i].sp;
            loop_l = tbl[i].lp;
            tick   = tbl[i].tk;
            sb.push_back(tbl[i]);
        end
        tbl.delete();
        @(negedge clk);
        start = 0; stop = 0; loop_l = 0; tick = 0;
        for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        start = 0; stop = 0; loop_l = 0; tick = 0;
        start2 = 0; stop2 = 0; loop2 = 0; tick2 = 0;
        for (int i = 0; i < 64; i++) begin
            mem1[i] = '0;
            mem2[i] = {1'b0, DW'(i % 3), 6'((i % 63) + 1)};
        end
        mem1[0] = {1'b0, 4'd2, 6'd10};
        mem1[1] = {1'b1, 4'd0, 6'd20};

        #12;
        chk("rst_gate", gate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);
        chk("rst_note", note, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic two-entry melody
        add(1,0,0,0,  0,0,1,0,0);
        add(0,0,0,0,  0,0,1,0,0);
        add(0,0,0,0, 10,1,1,0,0);
        add(0,0,0,1, 10,1,1,0,0);
        add(0,0,0,1, 10,1,1,0,0);
        add(0,0,0,0, 10,1,1,0,0);
        add(0,0,0,1, 10,0,1,0,0);
        add(0,0,0,1, 10,0,1,0,1);
        add(0,0,0,0, 10,0,1,0,1);
        add(0,0,0,0, 20,1,1,0,1);
        add(0,0,0,1, 20,0,1,0,1);
        add(0,0,0,1, 20,0,0,1,0);
        add(0,0,0,1, 20,0,0,0,0);
        // loop, then loop dropped during entry 0
        add(1,0,1,0, 20,0,1,0,0);
        add(0,0,1,0, 20,0,1,0,0);
        add(0,0,1,0, 10,1,1,0,0);
        add(0,0,1,1, 10,1,1,0,0);
        add(0,0,1,1, 10,1,1,0,0);
        add(0,0,1,1, 10,0,1,0,0);
        add(0,0,1,1, 10,0,1,0,1);
        add(0,0,1,0, 10,0,1,0,1);
        add(0,0,1,0, 20,1,1,0,1);
        add(0,0,1,1, 20,0,1,0,1);
        add(0,0,1,1, 20,0,1,0,0);
        add(0,0,0,0, 20,0,1,0,0);
        add(0,0,0,0, 10,1,1,0,0);
        add(0,0,0,1, 10,1,1,0,0);
        add(0,0,0,1, 10,1,1,0,0);
        add(0,0,0,1, 10,0,1,0,0);
        add(0,0,0,1, 10,0,1,0,1);
        add(0,0,0,0, 10,0,1,0,1);
        add(0,0,0,0, 20,1,1,0,1);
        add(0,0,0,1, 20,0,1,0,1);
        add(0,0,0,1, 20,0,0,1,0);
        // stop mid-note, stop+start in idle
        add(1,0,0,0, 20,0,1,0,0);
        add(0,0,0,0, 20,0,1,0,0);
        add(0,0,0,0, 10,1,1,0,0);
        add(0,0,0,1, 10,1,1,0,0);
        add(0,1,0,0, 10,0,0,0,0);
        add(0,0,0,0, 10,0,0,0,0);
        add(1,1,0,0, 10,0,0,0,0);
        add(0,0,0,0, 10,0,0,0,0);
        // start while playing is ignored; stop beats gap end
        add(1,0,0,0, 10,0,1,0,0);
        add(0,0,0,0, 10,0,1,0,0);
        add(0,0,0,0, 10,1,1,0,0);
        add(0,0,0,1, 10,1,1,0,0);
        add(1,0,0,0, 10,1,1,0,0);
        add(1,0,0,1, 10,1,1,0,0);
        add(0,0,0,1, 10,0,1,0,0);
        add(0,1,0,1, 10,0,0,0,0);
        run_table();

        // rest entry
        mem1[0] = {1'b1, 4'd1, 6'd0};
        add(1,0,0,0, 10,0,1,0,0);
        add(0,0,0,0, 10,0,1,0,0);
        add(0,0,0,0,  0,0,1,0,0);
        add(0,0,0,1,  0,0,1,0,0);
        add(0,0,0,1,  0,0,1,0,0);
        add(0,0,0,1,  0,0,0,1,0);
        add(0,0,0,0,  0,0,0,0,0);
        run_table();

        // async reset mid-PLAY
        mem1[0] = {1'b0, 4'd2, 6'd10};
        add(1,0,0,0,  0,0,1,0,0);
        add(0,0,0,0,  0,0,1,0,0);
        add(0,0,0,0, 10,1,1,0,0);
        run_table();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gate", gate, 0);
        chk("arst_busy", busy, 0);
        chk("arst_note", note, 0);
        chk("arst_addr", addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 0);
        end

        // legato 64-entry wrap, tick every clock
        @(negedge clk);
        start2 = 1; tick2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        chk("wrap_busy", busy2, 1);
        for (int i = 0; i < 66; i++) begin
            int j, d;
            j = i % 64;
            d = j % 3;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("wrap_note", note2, (j % 63) + 1);
            chk("wrap_addr", addr2, j);
            repeat (d) begin
                @(posedge clk); #1;
                chk("wrap_hold", addr2, j);
            end
            @(posedge clk); #1;
            chk("wrap_next", addr2, (j + 1) % 64);
        end
        @(negedge clk);
        stop2 = 1; tick2 = 0;
        @(posedge clk); #1;
        chk("wrap_stop_busy", busy2, 0);
        chk("wrap_stop_done", done2, 0);
        stop2 = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
